fdiv: RTL and testbench

Iterative IEEE-754 floating-point divider that sits next to the combinational add/multiply FPU datapath and supplies the inverse of its multiply operation. It divides half-precision (binary16) or single-precision (binary32) operands, producing one quotient bit per clock. A start/done handshake lets the processor stall while the divider is busy. Results are rounded to nearest-even, and a 4-bit exception flag vector is returned.

---
 rtl/fdiv_if.sv | 21 ++
 rtl/fdiv.sv | 248 ++++++++++++++++++++++++
 tb/tb_fdiv.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fdiv_if.sv
// rtl/fdiv_if.sv - start/done handshake and operand/result bundle for the fdiv divider
interface fdiv_if;
    logic        start;
    logic        Precision;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] Result;
    logic [3:0]  Flags;

    modport master (
        output start, Precision, A, B,
        input  busy, done, Result, Flags
    );

    modport slave (
        input  start, Precision, A, B,
        output busy, done, Result, Flags
    );
endinterface

// File: rtl/fdiv.sv
// rtl/fdiv.sv - iterative IEEE-754 divider, one quotient bit per clock; FDIV_FP16_EN adds binary16
module fdiv (
    input  logic  clk,
    input  logic  reset,
    fdiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DIV, RND, DONE} state_t;

    state_t            state;
    logic [4:0]        cnt;
    logic [4:0]        last;
    logic [25:0]       rem;
    logic [23:0]       dvs;
    logic [25:0]       quo;
    logic signed [9:0] exp_q;
    logic              sgn_q;

`ifdef FDIV_FP16_EN
    logic is16;
    logic in16;
    assign in16 = ~bus.Precision;
    assign last = is16 ? 5'd12 : 5'd25;
`else
    logic unused_prec;
    assign unused_prec = bus.Precision;
    assign last = 5'd25;
`endif

    logic              sa, sb, sr;
    logic signed [9:0] ea, eb, emax, bias;
    logic              fa_nz, fb_nz;
    logic [23:0]       ma, mb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    always_comb begin
        sa    = bus.A[31];
        sb    = bus.B[31];
        ea    = {2'b00, bus.A[30:23]};
        eb    = {2'b00, bus.B[30:23]};
        fa_nz = |bus.A[22:0];
        fb_nz = |bus.B[22:0];
        ma    = {1'b1, bus.A[22:0]};
        mb    = {1'b1, bus.B[22:0]};
        emax  = 10'sd255;
        bias  = 10'sd127;
`ifdef FDIV_FP16_EN
        if (in16) begin
            sa    = bus.A[15];
            sb    = bus.B[15];
            ea    = {5'b00000, bus.A[14:10]};
            eb    = {5'b00000, bus.B[14:10]};
            fa_nz = |bus.A[9:0];
            fb_nz = |bus.B[9:0];
            ma    = {13'd0, 1'b1, bus.A[9:0]};
            mb    = {13'd0, 1'b1, bus.B[9:0]};
            emax  = 10'sd31;
            bias  = 10'sd15;
        end
`endif
        sr     = sa ^ sb;
        // Denormal operands collapse to zero: only the exponent field is inspected.
        a_zero = (ea == 10'sd0);
        b_zero = (eb == 10'sd0);
        a_inf  = (ea == emax) && !fa_nz;
        b_inf  = (eb == emax) && !fb_nz;
        a_nan  = (ea == emax) && fa_nz;
        b_nan  = (eb == emax) && fb_nz;
    end

    logic        special;
    logic [31:0] sp_res, qnan, inf_v, zero_v;
    logic [3:0]  sp_flags;

    always_comb begin
        qnan   = 32'h7FC00000;
        inf_v  = {sr, 8'hFF, 23'd0};
        zero_v = {sr, 31'd0};
`ifdef FDIV_FP16_EN
        if (in16) begin
            qnan   = 32'h00007E00;
            inf_v  = {16'd0, sr, 5'h1F, 10'd0};
            zero_v = {16'd0, sr, 15'd0};
        end
`endif
        special  = 1'b1;
        sp_flags = 4'b0000;
        sp_res   = zero_v;
        if (a_nan || b_nan) begin
            sp_res = qnan;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            sp_res   = qnan;
            sp_flags = 4'b1000;
        end else if (a_inf) begin
            sp_res = inf_v;
        end else if (b_zero) begin
            sp_res   = inf_v;
            sp_flags = 4'b0100;
        end else if (b_inf || a_zero) begin
            sp_res = zero_v;
        end else begin
            special = 1'b0;
        end
    end

    logic [23:0]       mant;
    logic              guard, sticky, inc, carry, rem_nz;
    logic [24:0]       sum;
    logic signed [9:0] e_n, e_r, emax_r;
    logic [31:0]       rnd_res;
    logic [3:0]        rnd_flags;

    always_comb begin
        rem_nz = |rem;
        emax_r = 10'sd255;
        if (quo[25]) begin
            mant   = quo[25:2];
            guard  = quo[1];
            sticky = quo[0] | rem_nz;
            e_n    = exp_q;
        end else begin
            mant   = quo[24:1];
            guard  = quo[0];
            sticky = rem_nz;
            e_n    = exp_q - 10'sd1;
        end
`ifdef FDIV_FP16_EN
        if (is16) begin
            emax_r = 10'sd31;
            if (quo[12]) begin
                mant   = {13'd0, quo[12:2]};
                guard  = quo[1];
                sticky = quo[0] | rem_nz;
                e_n    = exp_q;
            end else begin
                mant   = {13'd0, quo[11:1]};
                guard  = quo[0];
                sticky = rem_nz;
                e_n    = exp_q - 10'sd1;
            end
        end
`endif
        inc   = guard & (sticky | mant[0]);
        sum   = {1'b0, mant} + {24'd0, inc};
        carry = sum[24];
        rnd_res = {sgn_q, e_r[7:0], sum[22:0]};
`ifdef FDIV_FP16_EN
        if (is16) begin
            carry = sum[11];
        end
`endif
        // A carry out of the mantissa leaves the fraction bits all zero, so only e moves.
        e_r       = e_n + $signed({9'd0, carry});
        rnd_flags = 4'b0000;
        rnd_res   = {sgn_q, e_r[7:0], sum[22:0]};
`ifdef FDIV_FP16_EN
        if (is16) begin
            rnd_res = {16'd0, sgn_q, e_r[4:0], sum[9:0]};
        end
`endif
        if (e_r >= emax_r) begin
            rnd_flags = 4'b0010;
            rnd_res   = {sgn_q, 8'hFF, 23'd0};
`ifdef FDIV_FP16_EN
            if (is16) begin
                rnd_res = {16'd0, sgn_q, 5'h1F, 10'd0};
            end
`endif
        end else if (e_r <= 10'sd0) begin
            rnd_flags = 4'b0001;
            rnd_res   = {sgn_q, 31'd0};
`ifdef FDIV_FP16_EN
            if (is16) begin
                rnd_res = {16'd0, sgn_q, 15'd0};
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            rem        <= '0;
            dvs        <= '0;
            quo        <= '0;
            exp_q      <= '0;
            sgn_q      <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.Result <= '0;
            bus.Flags  <= '0;
`ifdef FDIV_FP16_EN
            is16       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        sgn_q    <= sr;
                        exp_q    <= ea - eb + bias;
                        rem      <= {2'b00, ma};
                        dvs      <= mb;
                        quo      <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
`ifdef FDIV_FP16_EN
                        is16     <= in16;
`endif
                        if (special) begin
                            bus.Result <= sp_res;
                            bus.Flags  <= sp_flags;
                            bus.done   <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    // Partial remainder stays below 2*divisor, so bit 25 is never set.
                    if (rem >= {2'b00, dvs}) begin
                        rem <= (rem - {2'b00, dvs}) << 1;
                        quo <= {quo[24:0], 1'b1};
                    end else begin
                        rem <= rem << 1;
                        quo <= {quo[24:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == last) begin
                        state <= RND;
                    end
                end
                RND: begin
                    bus.Result <= rnd_res;
                    bus.Flags  <= rnd_flags;
                    bus.done   <= 1'b1;
                    state      <= DONE;
                end
                default: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fdiv.sv
// tb/tb_fdiv.sv - directed self-checking bench for fdiv
module tb_fdiv;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   edge_n = 0;
    int   busy_n = 0;
    bit   saw_done;

    fdiv_if bus ();

    fdiv dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
        if (bus.busy) busy_n++;
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic p);
        bus.A = a;
        bus.B = b;
        bus.Precision = p;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        edge_n = 0;
        busy_n = bus.busy ? 1 : 0;
    endtask

    task automatic wait_done();
        while (!bus.done && edge_n < 100) step();
    endtask

    task automatic expect_op(input string tag, input logic [31:0] res, input logic [3:0] flg,
                             input int lat);
        wait_done();
        chk({tag, "_lat"}, edge_n, lat);
        chk({tag, "_res"}, bus.Result, res);
        chk({tag, "_flags"}, {28'd0, bus.Flags}, {28'd0, flg});
        step();
        chk({tag, "_pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
        chk({tag, "_hold"}, bus.Result, res);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.Precision = 1'b1;
        bus.A = '0;
        bus.B = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_res", bus.Result, 32'd0);
        chk("rst_flags", {28'd0, bus.Flags}, 32'd0);
        reset = 1'b1;
        step();

        launch(32'h40C00000, 32'h40000000, 1'b1);
        wait_done();
        chk("six_busy_cycles", busy_n, 28);
        chk("six_lat", edge_n, 27);
        chk("six_res", bus.Result, 32'h40400000);
        step();

        launch(32'h3F800000, 32'h40400000, 1'b1);
        expect_op("third", 32'h3EAAAAAB, 4'b0000, 27);

        launch(32'hC0C00000, 32'h40000000, 1'b1);
        expect_op("neg", 32'hC0400000, 4'b0000, 27);

`ifdef FDIV_FP16_EN
        launch(32'h00003C00, 32'h00004200, 1'b0);
        expect_op("h_third", 32'h00003555, 4'b0000, 14);
        launch(32'h00003C00, 32'h00000000, 1'b0);
        expect_op("h_divz", 32'h00007C00, 4'b0100, 0);
`else
        launch(32'h40C00000, 32'h40000000, 1'b0);
        expect_op("prec_ign", 32'h40400000, 4'b0000, 27);
`endif

        launch(32'h3F800000, 32'h00000000, 1'b1);
        expect_op("divz", 32'h7F800000, 4'b0100, 0);
        launch(32'h00000000, 32'h00000000, 1'b1);
        expect_op("zz", 32'h7FC00000, 4'b1000, 0);
        launch(32'h7FC00001, 32'h3F800000, 1'b1);
        expect_op("nan", 32'h7FC00000, 4'b0000, 0);
        launch(32'hFF800000, 32'h40000000, 1'b1);
        expect_op("inf_fin", 32'hFF800000, 4'b0000, 0);
        launch(32'h40000000, 32'h7F800000, 1'b1);
        expect_op("fin_inf", 32'h00000000, 4'b0000, 0);

        launch(32'h7F7FFFFF, 32'h3E800000, 1'b1);
        expect_op("ovf", 32'h7F800000, 4'b0010, 27);
        launch(32'h00800000, 32'h40000000, 1'b1);
        expect_op("unf", 32'h00000000, 4'b0001, 27);

        launch(32'h40C00000, 32'h40000000, 1'b1);
        repeat (4) step();
        bus.A = 32'h3F800000;
        bus.B = 32'h40400000;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done();
        chk("busy_ign_lat", edge_n, 27);
        chk("busy_ign_res", bus.Result, 32'h40400000);
        bus.start = 1'b1;
        step();
        chk("done_ign", {30'd0, bus.done, bus.busy}, 32'd0);
        step();
        bus.start = 1'b0;
        edge_n = 0;
        chk("late_acc_busy", {31'd0, bus.busy}, 32'd1);
        expect_op("late_acc", 32'h3EAAAAAB, 4'b0000, 27);

        launch(32'h3F800000, 32'h40400000, 1'b1);
        repeat (9) step();
        reset = 1'b0;
        step();
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_res", bus.Result, 32'd0);
        chk("mid_rst_flags", {28'd0, bus.Flags}, 32'd0);
        reset = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            step();
            if (bus.done) saw_done = 1'b1;
        end
        chk("mid_rst_nodone", {31'd0, saw_done}, 32'd0);
        launch(32'h40C00000, 32'h40000000, 1'b1);
        expect_op("post_rst", 32'h40400000, 4'b0000, 27);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
